// File: rtl/wrr_vc_receiver_pkg.sv
// wrr_vc_receiver_pkg: shared link dimensions for the WRR arbiter, its receiver and testers
//   no ports; FIFO_DEPTH is also the credit count the arbiter reloads per VC after reset
package wrr_vc_receiver_pkg;
    localparam int DATA_W     = 4;
    localparam int NUM_VC     = 4;
    localparam int VC_W       = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 8;
endpackage

// File: rtl/wrr_vc_fifo.sv
// wrr_vc_fifo: one first-word-fall-through VC receive FIFO with credit-return pulse
//   CLK_2MHz, reset (async, active-high)
//   push/din     : write request and word; dropped internally when full
//   pop          : consumer pop; ignored when empty
//   out_valid    : non-empty; dout shows the head word, 0 when empty
//   full         : occupancy == FIFO_DEPTH
//   credit_ret   : registered, high the cycle after an accepted pop
module wrr_vc_fifo
    import wrr_vc_receiver_pkg::*;
(
    input  logic              CLK_2MHz,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              credit_ret
);
    localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    occ;
    logic              do_push, do_pop;
    // full and empty are judged on pre-edge occupancy, so a push to a full FIFO
    // is dropped even when a pop frees a slot on the same edge
    always_comb begin
        out_valid = occ != '0;
        full      = occ == DEPTH;
        do_pop    = pop & out_valid;
        do_push   = push & ~full;
        dout      = out_valid ? mem[rd_ptr] : '0;
    end
    always_ff @(posedge CLK_2MHz or posedge reset)
        if (reset) begin
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            credit_ret <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            occ        <= occ + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
            credit_ret <= do_pop;
        end
endmodule

// File: rtl/wrr_vc_receiver.sv
// wrr_vc_receiver: demultiplexes the WRR word stream into per-VC receive FIFOs
//   CLK_2MHz, reset (async, active-high)
//   in_valid/in_vc/in_data : serialized tagged word from the arbiter
//   pop                    : per-VC consumer pop
//   out_valid/out_data     : per-VC head word, VC i at [i*DATA_W +: DATA_W]
//   full, credit_ret       : per-VC full flag and credit-return pulse
//   overflow/overflow_vc   : sticky write-to-full flag and VC of the first one
//   rx_count               : accepted words, wrapping
module wrr_vc_receiver
    import wrr_vc_receiver_pkg::*;
(
    input  logic                     CLK_2MHz,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [VC_W-1:0]          in_vc,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [NUM_VC-1:0]        pop,
    output logic [NUM_VC-1:0]        out_valid,
    output logic [NUM_VC*DATA_W-1:0] out_data,
    output logic [NUM_VC-1:0]        full,
    output logic [NUM_VC-1:0]        credit_ret,
    output logic                     overflow,
    output logic [VC_W-1:0]          overflow_vc,
    output logic [CNT_W-1:0]         rx_count
);
    logic [NUM_VC-1:0] push;
    logic              accept, drop;
    always_comb begin
        push   = in_valid ? {{(NUM_VC-1){1'b0}}, 1'b1} << in_vc : '0;
        drop   = in_valid & full[in_vc];
        accept = in_valid & ~full[in_vc];
    end
    genvar i;
    generate
        for (i = 0; i < NUM_VC; i++) begin : g_vc
            wrr_vc_fifo u_fifo (
                .CLK_2MHz   (CLK_2MHz),
                .reset      (reset),
                .push       (push[i]),
                .pop        (pop[i]),
                .din        (in_data),
                .out_valid  (out_valid[i]),
                .dout       (out_data[i*DATA_W +: DATA_W]),
                .full       (full[i]),
                .credit_ret (credit_ret[i])
            );
        end
    endgenerate
    always_ff @(posedge CLK_2MHz or posedge reset)
        if (reset) begin
            overflow    <= 1'b0;
            overflow_vc <= '0;
            rx_count    <= '0;
        end else begin
            if (drop & ~overflow) begin
                overflow    <= 1'b1;
                overflow_vc <= in_vc;
            end
            rx_count <= rx_count + {{(CNT_W-1){1'b0}}, accept};
        end
endmodule

// File: tb/tb_wrr_vc_receiver.sv
// tb_wrr_vc_receiver: queue-based reference model with a negedge monitor for wrr_vc_receiver
module tb_wrr_vc_receiver;
    import wrr_vc_receiver_pkg::*;

    logic                     CLK_2MHz = 1'b0;
    logic                     reset    = 1'b1;
    logic                     in_valid = 1'b0;
    logic [VC_W-1:0]          in_vc    = '0;
    logic [DATA_W-1:0]        in_data  = '0;
    logic [NUM_VC-1:0]        pop      = '0;
    logic [NUM_VC-1:0]        out_valid;
    logic [NUM_VC*DATA_W-1:0] out_data;
    logic [NUM_VC-1:0]        full;
    logic [NUM_VC-1:0]        credit_ret;
    logic                     overflow;
    logic [VC_W-1:0]          overflow_vc;
    logic [CNT_W-1:0]         rx_count;

    wrr_vc_receiver dut (
        .CLK_2MHz    (CLK_2MHz),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_vc       (in_vc),
        .in_data     (in_data),
        .pop         (pop),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .full        (full),
        .credit_ret  (credit_ret),
        .overflow    (overflow),
        .overflow_vc (overflow_vc),
        .rx_count    (rx_count)
    );

    always #250 CLK_2MHz = ~CLK_2MHz;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q [NUM_VC][$];
    logic [NUM_VC-1:0] exp_credit = '0;
    logic              exp_ovf    = 1'b0;
    logic [VC_W-1:0]   exp_ovf_vc = '0;
    logic [CNT_W-1:0]  exp_cnt    = '0;
    int                cc [NUM_VC] = '{default: 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_VC; i++) q[i].delete();
        exp_credit = '0;
        exp_ovf    = 1'b0;
        exp_ovf_vc = '0;
        exp_cnt    = '0;
    endtask

    // one clock edge of the receiver as the link protocol describes it
    task automatic model_edge();
        int sz [NUM_VC];
        for (int i = 0; i < NUM_VC; i++) sz[i] = q[i].size();
        for (int i = 0; i < NUM_VC; i++) begin
            exp_credit[i] = pop[i] && sz[i] > 0;
            if (exp_credit[i]) void'(q[i].pop_front());
        end
        if (in_valid) begin
            if (sz[in_vc] == FIFO_DEPTH) begin
                if (!exp_ovf) begin
                    exp_ovf    = 1'b1;
                    exp_ovf_vc = in_vc;
                end
            end else begin
                q[in_vc].push_back(in_data);
                exp_cnt++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [VC_W-1:0] vc, input logic [DATA_W-1:0] d,
                        input logic [NUM_VC-1:0] p);
        in_valid = v;
        in_vc    = vc;
        in_data  = d;
        pop      = p;
        @(posedge CLK_2MHz);
        model_edge();
        #1;
        in_valid = 1'b0;
        pop      = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        #50;
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge CLK_2MHz);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] head(input int i);
        return out_data[i*DATA_W +: DATA_W];
    endfunction

    // monitor: every cycle compare DUT outputs against the model's queues
    initial forever begin
        @(negedge CLK_2MHz);
        for (int i = 0; i < NUM_VC; i++) begin
            chk($sformatf("out_valid[%0d]", i), int'(out_valid[i]), int'(q[i].size() != 0));
            if (out_valid[i] && pop[i] && q[i].size() != 0)
                chk($sformatf("pop_data[%0d]", i), int'(head(i)), int'(q[i][0]));
            else
                chk($sformatf("out_data[%0d]", i), int'(head(i)), q[i].size() != 0 ? int'(q[i][0]) : 0);
            chk($sformatf("full[%0d]", i), int'(full[i]), int'(q[i].size() == FIFO_DEPTH));
            chk($sformatf("credit_ret[%0d]", i), int'(credit_ret[i]), int'(exp_credit[i]));
            cc[i] += int'(credit_ret[i]);
        end
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("overflow_vc", int'(overflow_vc), int'(exp_ovf_vc));
        chk("rx_count", int'(rx_count), int'(exp_cnt));
    end

    int snap [NUM_VC];
    logic [VC_W-1:0] wrr_seq [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1};

    initial begin
        repeat (2) @(posedge CLK_2MHz);
        #1;
        reset = 1'b0;
        idle(1);

        // single word on vc2, then pop it
        step(1'b1, 2'd2, 4'h5, '0);
        chk("t2_valid", int'(out_valid), 4);
        chk("t2_data", int'(out_data[11:8]), 5);
        chk("t2_count", int'(rx_count), 1);
        step(1'b0, '0, '0, 4'b0100);
        chk("t2_credit", int'(credit_ret), 4);
        chk("t2_empty", int'(out_valid[2]), 0);
        idle(1);
        chk("t2_credit_end", int'(credit_ret), 0);

        // fill vc0, overflow it, drain in order
        do_reset();
        for (int k = 1; k <= 4; k++) step(1'b1, 2'd0, DATA_W'(k), '0);
        chk("t3_full", int'(full[0]), 1);
        step(1'b1, 2'd0, 4'h9, '0);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_ovf_vc", int'(overflow_vc), 0);
        chk("t3_count", int'(rx_count), 4);
        snap = cc;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t3_head%0d", k), int'(head(0)), k);
            step(1'b0, '0, '0, 4'b0001);
        end
        idle(1);
        chk("t3_credits", cc[0] - snap[0], 4);

        // weighted interleave 3/4/1, then drain everything
        snap = cc;
        foreach (wrr_seq[k]) step(1'b1, wrr_seq[k], DATA_W'($urandom), '0);
        repeat (5) step(1'b0, '0, '0, 4'hF);
        idle(1);
        chk("t4_cred0", cc[0] - snap[0], 3);
        chk("t4_cred1", cc[1] - snap[1], 4);
        chk("t4_cred2", cc[2] - snap[2], 1);
        chk("t4_cred3", cc[3] - snap[3], 0);

        // simultaneous push/pop on occupied vc1 and on empty vc3
        step(1'b1, 2'd1, 4'hA, '0);
        step(1'b1, 2'd1, 4'hB, '0);
        step(1'b1, 2'd1, 4'hC, 4'b0010);
        chk("t5_head", int'(head(1)), 11);
        chk("t5_credit", int'(credit_ret[1]), 1);
        chk("t5_not_full", int'(full[1]), 0);
        step(1'b1, 2'd3, 4'h6, 4'b1000);
        chk("t5_vc3_valid", int'(out_valid[3]), 1);
        chk("t5_vc3_credit", int'(credit_ret[3]), 0);
        idle(1);

        // reset mid-cycle while vc1 holds two words and a pop is pending
        pop = 4'b0010;
        #100;
        reset = 1'b1;
        #1;
        model_reset();
        chk("t1_valid", int'(out_valid), 0);
        chk("t1_data", int'(out_data), 0);
        chk("t1_full", int'(full), 0);
        chk("t1_credit", int'(credit_ret), 0);
        chk("t1_ovf", int'(overflow), 0);
        chk("t1_ovf_vc", int'(overflow_vc), 0);
        chk("t1_count", int'(rx_count), 0);
        @(posedge CLK_2MHz);
        #1;
        chk("t1_no_credit", int'(credit_ret), 0);
        pop   = '0;
        reset = 1'b0;
        idle(2);

        // random traffic with sparse pops so FIFOs fill and overflow
        repeat (400)
            step(1'($urandom_range(0, 3) != 0), VC_W'($urandom), DATA_W'($urandom),
                 NUM_VC'($urandom) & NUM_VC'($urandom));
        repeat (6) step(1'b0, '0, '0, 4'hF);

        // 256 accepted words with continuous pops: counter wraps, no overflow
        do_reset();
        repeat (256) step(1'b1, VC_W'($urandom), DATA_W'($urandom), 4'hF);
        chk("t6_wrap", int'(rx_count), 0);
        chk("t6_no_ovf", int'(overflow), 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
